// File: rtl/cpu_timing_pkg.sv
// cpu_timing_pkg: shared state encodings and default timing constants for the CPU phase generator
package cpu_timing_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, WAIT = 2'd2} state_t;
  localparam int CYCLE_LEN_DEF = 8;
  localparam int FETCH_LEN_DEF = 4;
  localparam int ALU_PHASE_DEF = 5;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up counter with enable and synchronous clear
module mod_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  // >= rather than == so an out-of-range count returns to 0 on the next advance
  assign wrap = int'(count) >= MODULUS - 1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/phase_gen.sv
// phase_gen: instruction-cycle phase counter and strobe generator with halt and single-step support
module phase_gen
  import cpu_timing_pkg::*;
#(
  parameter int CYCLE_LEN = CYCLE_LEN_DEF,
  parameter int FETCH_LEN = FETCH_LEN_DEF,
  parameter int ALU_PHASE = ALU_PHASE_DEF,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             step_mode,
  input  logic             step,
  output logic             clk1,
  output logic             fetch,
  output logic             con_alu,
  output logic             cycle_start,
  output logic [CNT_W-1:0] phase,
  output logic             stopped
);
  state_t r_state;
  logic   w_adv;
  logic   w_wrap;
  logic   w_in_wait;
  assign clk1      = ~clk;
  assign w_in_wait = r_state == WAIT;
  assign w_adv     = !w_in_wait && !halt;
  mod_counter #(.WIDTH(CNT_W), .MODULUS(CYCLE_LEN)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_adv),
    .clear (w_in_wait),
    .count (phase),
    .wrap  (w_wrap)
  );
  // HOLD and unused encodings share the RUN edge behaviour once halt drops
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= RUN;
      fetch       <= 1'b0;
      con_alu     <= 1'b0;
      cycle_start <= 1'b0;
      stopped     <= 1'b0;
    end else if (w_in_wait) begin
      fetch       <= 1'b0;
      con_alu     <= 1'b0;
      cycle_start <= 1'b0;
      if (!halt && (step || !step_mode)) begin
        r_state <= RUN;
        stopped <= 1'b0;
      end
    end else if (halt) begin
      r_state     <= HOLD;
      con_alu     <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      fetch       <= int'(phase) < FETCH_LEN;
      con_alu     <= int'(phase) == ALU_PHASE;
      cycle_start <= phase == '0;
      r_state     <= (w_wrap && step_mode) ? WAIT : RUN;
      stopped     <= w_wrap && step_mode;
    end
endmodule

// File: tb/tb_phase_gen.sv
// tb_phase_gen: directed vector bench for phase_gen at default and 6/2/3 parameterisations
module tb_phase_gen;
  typedef struct packed {
    logic [2:0] in;
    logic [6:0] out;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;
  logic clk1, fetch, con_alu, cycle_start, stopped;
  logic [2:0] phase;
  logic clk1_2, fetch2, con_alu2, cycle_start2, stopped2;
  logic [2:0] phase2;
  int n_vec = 0;
  int n_err = 0;
  vec_t tv[$];
  logic [5:0] exp2 [6];
  logic [6:0] exp_rel [3];

  always #5 clk = ~clk;

  phase_gen dut (
    .clk(clk), .rst(rst), .halt(halt), .step_mode(step_mode), .step(step),
    .clk1(clk1), .fetch(fetch), .con_alu(con_alu), .cycle_start(cycle_start),
    .phase(phase), .stopped(stopped)
  );

  phase_gen #(.CYCLE_LEN(6), .FETCH_LEN(2), .ALU_PHASE(3), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .halt(halt), .step_mode(step_mode), .step(step),
    .clk1(clk1_2), .fetch(fetch2), .con_alu(con_alu2), .cycle_start(cycle_start2),
    .phase(phase2), .stopped(stopped2)
  );

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b ({phase,fetch,con_alu,cycle_start,stopped})", nm, act, exp);
    end
  endtask

  // in = {halt, step_mode, step}; out = {phase, fetch, con_alu, cycle_start, stopped} after the edge
  task automatic add(input logic [2:0] in, input logic [6:0] out);
    tv.push_back({in, out});
  endtask

  task automatic p8(input logic sm, input logic lp);
    add({1'b0, sm, 1'b0}, 7'b001_1_0_1_0);
    add({1'b0, sm, 1'b0}, 7'b010_1_0_0_0);
    add({1'b0, sm, 1'b0}, 7'b011_1_0_0_0);
    add({1'b0, sm, 1'b0}, 7'b100_1_0_0_0);
    add({1'b0, sm, 1'b0}, 7'b101_0_0_0_0);
    add({1'b0, sm, 1'b0}, 7'b110_0_1_0_0);
    add({1'b0, sm, 1'b0}, 7'b111_0_0_0_0);
    add({1'b0, sm, 1'b0}, {6'b000_0_0_0, lp});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    exp2 = '{6'b001_1_0_1, 6'b010_1_0_0, 6'b011_0_0_0, 6'b100_0_1_0, 6'b101_0_0_0, 6'b000_0_0_0};
    exp_rel = '{7'b001_1_0_1_0, 7'b010_1_0_0_0, 7'b011_1_0_0_0};
    // free run, three full cycles
    for (int k = 0; k < 3; k++) p8(1'b0, 1'b0);
    // halt for three edges at phase 5; a step outside WAIT is ignored
    add(3'b000, 7'b001_1_0_1_0);
    add(3'b000, 7'b010_1_0_0_0);
    add(3'b001, 7'b011_1_0_0_0);
    add(3'b000, 7'b100_1_0_0_0);
    add(3'b000, 7'b101_0_0_0_0);
    add(3'b100, 7'b101_0_0_0_0);
    add(3'b100, 7'b101_0_0_0_0);
    add(3'b100, 7'b101_0_0_0_0);
    add(3'b000, 7'b110_0_1_0_0);
    add(3'b000, 7'b111_0_0_0_0);
    add(3'b000, 7'b000_0_0_0_0);
    // halt at phase 1: fetch held, cycle_start dropped and not repeated
    add(3'b000, 7'b001_1_0_1_0);
    add(3'b100, 7'b001_1_0_0_0);
    add(3'b000, 7'b010_1_0_0_0);
    add(3'b000, 7'b011_1_0_0_0);
    add(3'b000, 7'b100_1_0_0_0);
    add(3'b000, 7'b101_0_0_0_0);
    add(3'b000, 7'b110_0_1_0_0);
    add(3'b000, 7'b111_0_0_0_0);
    add(3'b000, 7'b000_0_0_0_0);
    // step mode: park, halt+step dropped, step releases exactly one cycle
    p8(1'b1, 1'b1);
    add(3'b010, 7'b000_0_0_0_1);
    add(3'b111, 7'b000_0_0_0_1);
    add(3'b010, 7'b000_0_0_0_1);
    add(3'b011, 7'b000_0_0_0_0);
    p8(1'b1, 1'b1);
    add(3'b010, 7'b000_0_0_0_1);
    // step_mode cleared while parked: leave WAIT without a step
    add(3'b000, 7'b000_0_0_0_0);
    add(3'b000, 7'b001_1_0_1_0);
    add(3'b000, 7'b010_1_0_0_0);
    add(3'b000, 7'b011_1_0_0_0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut", {phase, fetch, con_alu, cycle_start, stopped}, 7'b0);
    chk("reset_dut2", {phase2, fetch2, con_alu2, cycle_start2, stopped2}, 7'b0);
    chk("clk1_high", {6'b0, clk1}, 7'd0);
    @(negedge clk);
    rst = 1'b1;
    foreach (tv[i]) begin
      {halt, step_mode, step} = tv[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", i), {phase, fetch, con_alu, cycle_start, stopped}, tv[i].out);
      if (i < 24)
        chk($sformatf("cfg6_row%0d", i), {phase2, fetch2, con_alu2, cycle_start2, stopped2}, {exp2[i % 6], 1'b0});
      @(negedge clk);
    end
    {halt, step_mode, step} = 3'b000;
    rst = 1'b0;
    #1;
    chk("async_reset", {phase, fetch, con_alu, cycle_start, stopped}, 7'b0);
    chk("async_reset_cfg6", {phase2, fetch2, con_alu2, cycle_start2, stopped2}, 7'b0);
    chk("clk1_low", {6'b0, clk1}, 7'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset%0d", k), {phase, fetch, con_alu, cycle_start, stopped}, exp_rel[k]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
